// File: rtl/controle_display.sv
// Display source controller: shows the number by default and, on a letter request,
// switches the 7-segment converter to the letter for HOLD*DIV cycles before returning.
module controle_display #(
    parameter int DIV  = 50000,
    parameter int HOLD = 200
) (
    input  logic       clock,
    input  logic       zera_as_n,
    input  logic       zera_s,
    input  logic       num_valid,
    input  logic [7:0] num_dado,
    output logic       num_ready,
    input  logic       let_valid,
    input  logic [4:0] let_dado,
    output logic       let_ready,
    output logic [7:0] numero,
    output logic [4:0] letra,
    output logic       select,
    output logic       zera_contador_display,
    output logic [1:0] db_estado
);

    localparam int W_PRESC = (DIV  > 1) ? $clog2(DIV)  : 1;
    localparam int W_HOLD  = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [W_PRESC-1:0] PRESC_MAX = W_PRESC'(DIV - 1);
    localparam logic [W_HOLD-1:0]  HOLD_MAX  = W_HOLD'(HOLD - 1);

    typedef enum logic [1:0] {
        NUM     = 2'd0,
        CARREGA = 2'd1,
        MOSTRA  = 2'd2,
        VOLTA   = 2'd3
    } estado_t;

    estado_t              r_estado;
    estado_t              w_prox;
    logic [7:0]           r_numero;
    logic [4:0]           r_letra;
    logic                 r_select;
    logic                 r_zera;
    logic [W_PRESC-1:0]   r_presc;
    logic [W_HOLD-1:0]    r_hold;
    logic                 w_num_fire;
    logic                 w_let_fire;
    logic                 w_tick;
    logic                 w_fim;

    assign num_ready = ~zera_s;
    assign let_ready = ~zera_s & ((r_estado == NUM) | (r_estado == MOSTRA));

    assign w_num_fire = num_valid & num_ready;
    assign w_let_fire = let_valid & let_ready;
    assign w_tick     = (r_estado == MOSTRA) && (r_presc == PRESC_MAX);
    assign w_fim      = w_tick && (r_hold == HOLD_MAX);

    // A letter accepted in MOSTRA restarts the display ahead of hold expiry.
    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            NUM:     if (w_let_fire) w_prox = CARREGA;
            CARREGA: w_prox = MOSTRA;
            MOSTRA: begin
                if (w_let_fire)
                    w_prox = CARREGA;
                else if (w_fim)
                    w_prox = VOLTA;
            end
            VOLTA:   w_prox = NUM;
            default: w_prox = NUM;
        endcase
    end

    always_ff @(posedge clock or negedge zera_as_n) begin
        if (!zera_as_n) begin
            r_estado <= NUM;
            r_numero <= '0;
            r_letra  <= '0;
            r_select <= 1'b0;
            r_zera   <= 1'b0;
            r_presc  <= '0;
            r_hold   <= '0;
        end else if (zera_s) begin
            r_estado <= NUM;
            r_numero <= '0;
            r_letra  <= '0;
            r_select <= 1'b0;
            r_zera   <= 1'b0;
            r_presc  <= '0;
            r_hold   <= '0;
        end else begin
            if (w_num_fire)
                r_numero <= num_dado;
            if (w_let_fire)
                r_letra <= let_dado;
            r_estado <= w_prox;
            r_select <= (w_prox == CARREGA) || (w_prox == MOSTRA);
            r_zera   <= (w_prox == CARREGA) || (w_prox == VOLTA);
            // Counters only run while staying in MOSTRA; any other next state zeroes them.
            if ((w_prox != MOSTRA) || (r_estado != MOSTRA)) begin
                r_presc <= '0;
                r_hold  <= '0;
            end else if (w_tick) begin
                r_presc <= '0;
                r_hold  <= r_hold + W_HOLD'(1);
            end else begin
                r_presc <= r_presc + W_PRESC'(1);
            end
        end
    end

    assign numero                = r_numero;
    assign letra                 = r_letra;
    assign select                = r_select;
    assign zera_contador_display = r_zera;
    assign db_estado             = r_estado;

endmodule

// File: tb/tb_controle_display.sv
// Directed bench for controle_display with DIV=4, HOLD=3 (MOSTRA lasts 12 cycles).
module tb_controle_display;

    logic       clock = 1'b0;
    logic       zera_as_n;
    logic       zera_s;
    logic       num_valid;
    logic [7:0] num_dado;
    logic       num_ready;
    logic       let_valid;
    logic [4:0] let_dado;
    logic       let_ready;
    logic [7:0] numero;
    logic [4:0] letra;
    logic       select;
    logic       zera_contador_display;
    logic [1:0] db_estado;

    int vectors = 0;
    int errors  = 0;

    controle_display #(.DIV(4), .HOLD(3)) dut (
        .clock                 (clock),
        .zera_as_n             (zera_as_n),
        .zera_s                (zera_s),
        .num_valid             (num_valid),
        .num_dado              (num_dado),
        .num_ready             (num_ready),
        .let_valid             (let_valid),
        .let_dado              (let_dado),
        .let_ready             (let_ready),
        .numero                (numero),
        .letra                 (letra),
        .select                (select),
        .zera_contador_display (zera_contador_display),
        .db_estado             (db_estado)
    );

    always #5 clock = ~clock;

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    // Expected {db_estado, select, zera} per state.
    function automatic logic [3:0] moore(input logic [1:0] st);
        case (st)
            2'd0:    return 4'b00_0_0;
            2'd1:    return 4'b01_1_1;
            2'd2:    return 4'b10_1_0;
            default: return 4'b11_0_1;
        endcase
    endfunction

    task automatic test_reset;
        zera_as_n = 1'b0; zera_s = 1'b0;
        num_valid = 1'b0; num_dado = '0;
        let_valid = 1'b0; let_dado = '0;
        #3;
        vectors++;
        if ({db_estado, select, zera_contador_display, numero, letra} !== 17'd0) begin
            errors++;
            $display("FAIL reset_hold st=%0d sel=%0b z=%0b num=%0d let=%0d want all 0",
                     db_estado, select, zera_contador_display, numero, letra);
        end
        step; step;
        zera_as_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step;
            vectors++;
            if ({db_estado, select, zera_contador_display, numero, letra, num_ready, let_ready}
                    !== {17'd0, 2'b11}) begin
                errors++;
                $display("FAIL reset_idle c=%0d st=%0d sel=%0b z=%0b num=%0d let=%0d nr=%0b lr=%0b want 0/0/0/0/0/1/1",
                         c, db_estado, select, zera_contador_display, numero, letra, num_ready, let_ready);
            end
        end
    endtask

    task automatic test_numero;
        num_valid = 1'b1; num_dado = 8'd173;
        step;
        num_valid = 1'b0;
        vectors++;
        if ({numero, db_estado, select, zera_contador_display} !== {8'd173, 4'b0000}) begin
            errors++;
            $display("FAIL numero num=%0d st=%0d sel=%0b z=%0b want 173/0/0/0",
                     numero, db_estado, select, zera_contador_display);
        end
    endtask

    task automatic test_letra;
        logic [1:0] exp_st;
        let_valid = 1'b1; let_dado = 5'd7;
        for (int c = 1; c <= 16; c++) begin
            step;
            let_valid = 1'b0;
            exp_st = (c == 1) ? 2'd1 : (c <= 13) ? 2'd2 : (c == 14) ? 2'd3 : 2'd0;
            vectors++;
            if ({db_estado, select, zera_contador_display} !== moore(exp_st) ||
                letra !== 5'd7 || numero !== 8'd173 ||
                let_ready !== (exp_st == 2'd0 || exp_st == 2'd2)) begin
                errors++;
                $display("FAIL letra c=%0d st=%0d sel=%0b z=%0b let=%0d num=%0d lr=%0b want st=%0d let=7 num=173",
                         c, db_estado, select, zera_contador_display, letra, numero, let_ready, exp_st);
            end
        end
    endtask

    task automatic test_retrigger;
        logic [1:0] exp_st;
        logic [4:0] exp_let;
        let_valid = 1'b1; let_dado = 5'd7;
        for (int c = 1; c <= 23; c++) begin
            step;
            exp_st = (c == 1 || c == 9) ? 2'd1 : (c <= 21) ? 2'd2 : (c == 22) ? 2'd3 : 2'd0;
            exp_let = (c < 9) ? 5'd7 : 5'd9;
            vectors++;
            if ({db_estado, select, zera_contador_display} !== moore(exp_st) || letra !== exp_let) begin
                errors++;
                $display("FAIL retrigger c=%0d st=%0d sel=%0b z=%0b let=%0d want st=%0d let=%0d",
                         c, db_estado, select, zera_contador_display, letra, exp_st, exp_let);
            end
            let_valid = (c == 8);
            let_dado  = 5'd9;
        end
        let_valid = 1'b0;
    endtask

    task automatic test_retrigger_at_expiry;
        let_valid = 1'b1; let_dado = 5'd2;
        for (int c = 1; c <= 13; c++) begin
            step;
            let_valid = (c == 13);
            let_dado  = 5'd4;
        end
        step;
        let_valid = 1'b0;
        vectors++;
        if ({db_estado, select, zera_contador_display} !== moore(2'd1) || letra !== 5'd4) begin
            errors++;
            $display("FAIL retrig_expiry st=%0d sel=%0b z=%0b let=%0d want st=1 let=4",
                     db_estado, select, zera_contador_display, letra);
        end
        repeat (16) step;
        vectors++;
        if (db_estado !== 2'd0) begin
            errors++;
            $display("FAIL retrig_expiry_end st=%0d want 0", db_estado);
        end
    endtask

    task automatic test_back_to_back;
        num_valid = 1'b1; num_dado = 8'd42;
        let_valid = 1'b1; let_dado = 5'd3;
        step;
        num_valid = 1'b0;
        let_dado  = 5'd5;
        vectors++;
        if ({numero, letra} !== {8'd42, 5'd3} || {db_estado, select, zera_contador_display} !== moore(2'd1) ||
            let_ready !== 1'b0) begin
            errors++;
            $display("FAIL simult num=%0d let=%0d st=%0d lr=%0b want 42/3/1/0",
                     numero, letra, db_estado, let_ready);
        end
        step;
        let_valid = 1'b0;
        vectors++;
        if (letra !== 5'd3 || db_estado !== 2'd2 || zera_contador_display !== 1'b0) begin
            errors++;
            $display("FAIL simult_hold let=%0d st=%0d z=%0b want 3/2/0", letra, db_estado, zera_contador_display);
        end
        repeat (14) step;
        vectors++;
        if (db_estado !== 2'd0 || numero !== 8'd42) begin
            errors++;
            $display("FAIL simult_end st=%0d num=%0d want 0/42", db_estado, numero);
        end
    endtask

    task automatic test_async_reset;
        let_valid = 1'b1; let_dado = 5'd7;
        for (int c = 1; c <= 6; c++) begin
            step;
            let_valid = 1'b0;
        end
        #2 zera_as_n = 1'b0;
        #1;
        vectors++;
        if ({db_estado, select, zera_contador_display, numero, letra} !== 17'd0) begin
            errors++;
            $display("FAIL async_reset st=%0d sel=%0b z=%0b num=%0d let=%0d want all 0",
                     db_estado, select, zera_contador_display, numero, letra);
        end
        #2 zera_as_n = 1'b1;
        for (int c = 0; c < 16; c++) begin
            step;
            vectors++;
            if ({db_estado, select, zera_contador_display} !== 4'b0000) begin
                errors++;
                $display("FAIL async_no_volta c=%0d st=%0d sel=%0b z=%0b want 0/0/0",
                         c, db_estado, select, zera_contador_display);
            end
        end
    endtask

    task automatic test_sync_clear;
        num_valid = 1'b1; num_dado = 8'd99;
        let_valid = 1'b1; let_dado = 5'd11;
        step; step; step;
        zera_s = 1'b1; num_dado = 8'd77; let_dado = 5'd12;
        #1;
        vectors++;
        if ({num_ready, let_ready} !== 2'b00) begin
            errors++;
            $display("FAIL zera_s_ready nr=%0b lr=%0b want 0/0", num_ready, let_ready);
        end
        step;
        zera_s = 1'b0; num_valid = 1'b0; let_valid = 1'b0;
        vectors++;
        if ({db_estado, select, zera_contador_display, numero, letra} !== 17'd0) begin
            errors++;
            $display("FAIL zera_s st=%0d sel=%0b z=%0b num=%0d let=%0d want all 0",
                     db_estado, select, zera_contador_display, numero, letra);
        end
        repeat (16) step;
        vectors++;
        if ({db_estado, select, zera_contador_display} !== 4'b0000) begin
            errors++;
            $display("FAIL zera_s_after st=%0d want 0", db_estado);
        end
    endtask

    initial begin
        test_reset;
        test_numero;
        test_letra;
        test_retrigger;
        test_retrigger_at_expiry;
        test_back_to_back;
        test_async_reset;
        test_sync_clear;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
